pq_request_arbiter: RTL and testbench
=====================================

Name: pq_request_arbiter

Overview:
- Shares one pipelined register-array priority queue between NUM_REQ requesters.
- Round-robin arbitration over valid/ready requests, one queue operation at a time.
- Enforces a settle gap after every operation so the odd/even compare-swap phases restore the true maximum to the head before the next operation.
- Rejects illegal operations (push when full, pop when empty) with an error response, without touching the queue.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 16, queue element width.
- SETTLE_CYCLES, 2, idle cycles after each issued op (>=1; 2 covers one even and one odd phase).

Ports:
- i_CLK  input  1  clock.
- i_RST  input  1  reset, synchronous, active-high.
- i_req_valid  input  NUM_REQ  per-requester request valid.
- o_req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- i_req_op  input  2*NUM_REQ  per-requester opcode: 01 push, 10 pop, 11 replace, 00 illegal.
- i_req_data  input  DATA_WIDTH*NUM_REQ  per-requester push/replace data.
- o_rsp_valid  output  NUM_REQ  one-hot response strobe, one cycle.
- o_rsp_data  output  DATA_WIDTH  pre-op queue head for pop/replace; 0 for push or error.
- o_rsp_err  output  1  response qualifier: op rejected.
- o_q_wrt  output  1  to queue i_wrt.
- o_q_read  output  1  to queue i_read.
- o_q_data  output  DATA_WIDTH  to queue i_data.
- i_q_full  input  1  from queue o_full.
- i_q_empty  input  1  from queue o_empty.
- i_q_head  input  DATA_WIDTH  from queue o_data.

Behaviour:
- Reset (i_RST high at a clock edge): state IDLE, RR pointer 0, settle counter 0, captured-op registers 0. All outputs are 0 the cycle after reset. Reset mid-op aborts with no strobe and no response.
- States and transitions:
  - IDLE: grant g = first index with i_req_valid set, scanning from the pointer upward with wrap. Assert o_req_ready[g] combinationally. On the edge, capture g, op and data; pointer <= (g+1) mod NUM_REQ; go to ISSUE. No valid requests: stay in IDLE.
  - ISSUE (exactly 1 cycle):
    - err = (op==00) | (op==01 & i_q_full) | (op==10 & i_q_empty).
    - If not err: o_q_wrt = op[0], o_q_read = op[1], o_q_data = captured data.
    - If err: strobes stay 0.
    - In both cases, o_rsp_valid[g] = 1 and o_rsp_err = err.
    - o_rsp_data = i_q_head when op is 10 or 11 and not err; otherwise 0.
    - Go to SETTLE with counter = SETTLE_CYCLES-1.
  - SETTLE: no ready, no strobes. Counter decrements each cycle; at 0, go to IDLE.
- Error ops also pass through SETTLE, so timing is uniform.
- Replace on an empty queue is legal (the queue inserts the data); the response data is the current head (0).
- Latency: accept at cycle t, queue strobe and response at t+1, earliest next accept at t+2+SETTLE_CYCLES.
- o_q_wrt and o_q_read are never high outside ISSUE. Only one queue op is in flight.
- A requester holds valid, op and data stable until ready. Dropping valid before grant is allowed.
- Fairness: a continuously-valid requester is granted within NUM_REQ accepts.

Optional Feature:
- Macro: PQ_ARB_STATS_EN.
- Defined:
  - Adds output o_grant_cnt (32*NUM_REQ): per-requester accept counters.
  - Adds output o_err_cnt (32): error-response counter.
  - Counters saturate at all-ones and clear on i_RST.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package pq_arb_pkg holds:
  - typedef pq_op_e: OP_ILLEGAL=2'b00, OP_PUSH=2'b01, OP_POP=2'b10, OP_REPLACE=2'b11.
  - typedef arb_state_e: IDLE, ISSUE, SETTLE.
  - function rr_pick(valid, ptr).
- One sub-module, pq_rr_grant: combinational round-robin pick from valid and pointer, giving a one-hot grant and an index.
- FSM, capture registers and counters stay in the top module.

Test Plan:
- Reset, then empty queue; req0 pushes 0x0010 -> o_q_wrt=1 for one cycle, rsp_valid[0], err=0, data=0; next ready no earlier than 3 cycles after accept.
- req0..3 all valid pushing 5,9,3,7 -> grant order 0,1,2,3. A later pop by req1 returns 0x0009; a later pop by req2 returns 0x0007.
- Pop on empty queue by req2 -> rsp_err=1, data=0, o_q_read never asserted, queue unchanged.
- QUEUE_SIZE=4 full of 4,3,2,1; req3 push 8 -> err=1. Then req3 replace 8 -> o_q_wrt=o_q_read=1, response 0x0004, next pop returns 0x0008.
- req0 held valid continuously while req1 toggles -> req0 and req1 alternate grants; no starvation over 20 accepts.
- Assert i_RST during ISSUE -> next cycle all outputs 0, no response; then a req2 request is the first one granted.

Source files
------------

// File: rtl/pq_arb_pkg.sv
// Shared types and the round-robin pick helper for the priority-queue request arbiter.
package pq_arb_pkg;

  typedef enum logic [1:0] {
    OP_ILLEGAL = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } pq_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } arb_state_e;

  localparam int unsigned MAX_REQ = 32;

  // First set bit of valid at or above ptr, wrapping at n; returns ptr when nothing is set.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    rr_pick = ptr;
    for (int unsigned k = MAX_REQ; k > 0; k--) begin
      if (k <= n) begin
        idx = ptr + k - 1;
        if (idx >= n) idx = idx - n;
        if ((valid & (MAX_REQ'(1) << idx)) != '0) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/pq_rr_grant.sv
// Combinational round-robin grant: one-hot grant and index from request valids and pointer.
module pq_rr_grant
  import pq_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [MAX_REQ-1:0] valid_ext;
  int unsigned        pick;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = i_valid;
    pick                     = rr_pick(valid_ext, 32'(i_ptr), NUM_REQ);
    o_idx                    = IDX_W'(pick);
    o_any                    = |i_valid;
    o_grant                  = '0;
    if (o_any) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/pq_request_arbiter.sv
// Round-robin arbiter sharing one pipelined priority queue between NUM_REQ requesters.
// Optional PQ_ARB_STATS_EN adds saturating per-requester grant and error counters.
module pq_request_arbiter
  import pq_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                          i_CLK,
  input  logic                          i_RST,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [2*NUM_REQ-1:0]          i_req_op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_rsp_err,
  output logic                          o_q_wrt,
  output logic                          o_q_read,
  output logic [DATA_WIDTH-1:0]         o_q_data,
  input  logic                          i_q_full,
  input  logic                          i_q_empty,
  input  logic [DATA_WIDTH-1:0]         i_q_head
`ifdef PQ_ARB_STATS_EN
  ,
  output logic [32*NUM_REQ-1:0]         o_grant_cnt,
  output logic [31:0]                   o_err_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES) + 1;

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q;
  logic [CNT_W-1:0]      settle_q;
  logic [IDX_W-1:0]      cap_idx_p0;
  pq_op_e                cap_op_p0;
  logic [DATA_WIDTH-1:0] cap_data_p0;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_any;
  logic                  accept, issue, err;

  pq_rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_grant (
    .i_valid (i_req_valid),
    .i_ptr   (ptr_q),
    .o_grant (grant),
    .o_idx   (grant_idx),
    .o_any   (grant_any)
  );

  assign accept = (state_q == IDLE) && grant_any && !i_RST;
  assign issue  = (state_q == ISSUE) && !i_RST;

  always_comb begin
    err = 1'b1;
    unique case (cap_op_p0)
      OP_PUSH:    err = i_q_full;
      OP_POP:     err = i_q_empty;
      OP_REPLACE: err = 1'b0;
      default:    err = 1'b1;
    endcase
  end

  // Stage p0: capture of the granted request, consumed by the ISSUE cycle
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      settle_q    <= '0;
      cap_idx_p0  <= '0;
      cap_op_p0   <= OP_ILLEGAL;
      cap_data_p0 <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cap_idx_p0  <= grant_idx;
        cap_op_p0   <= pq_op_e'(i_req_op[grant_idx*2 +: 2]);
        cap_data_p0 <= i_req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        ptr_q       <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
      end
      if (issue) settle_q <= CNT_W'(SETTLE_CYCLES-1);
      else if (state_q == SETTLE && settle_q != '0) settle_q <= settle_q - CNT_W'(1);
    end
  end

  // Outputs are masked while reset is asserted so an aborted op never reaches the queue
  always_comb begin
    state_d     = state_q;
    o_req_ready = '0;
    o_rsp_valid = '0;
    o_rsp_data  = '0;
    o_rsp_err   = 1'b0;
    o_q_wrt     = 1'b0;
    o_q_read    = 1'b0;
    o_q_data    = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d = ISSUE;
          if (!i_RST) o_req_ready = grant;
        end
      end
      ISSUE: begin
        state_d = SETTLE;
        if (!i_RST) begin
          o_rsp_valid[cap_idx_p0] = 1'b1;
          o_rsp_err               = err;
          if (!err) begin
            o_q_wrt  = cap_op_p0[0];
            o_q_read = cap_op_p0[1];
            o_q_data = cap_data_p0;
            if (cap_op_p0[1]) o_rsp_data = i_q_head;
          end
        end
      end
      SETTLE: begin
        if (settle_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PQ_ARB_STATS_EN
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_grant_cnt <= '0;
      o_err_cnt   <= '0;
    end else begin
      if (accept && o_grant_cnt[grant_idx*32 +: 32] != '1)
        o_grant_cnt[grant_idx*32 +: 32] <= o_grant_cnt[grant_idx*32 +: 32] + 32'd1;
      if (issue && err && o_err_cnt != '1)
        o_err_cnt <= o_err_cnt + 32'd1;
    end
  end
`else
  // Default build carries no statistics counters.
`endif

endmodule

// File: tb/tb_pq_request_arbiter.sv
// Randomized self-checking bench: behavioural priority queue plus an arbitration reference model.
module tb_pq_request_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 16;
  localparam int SETTLE  = 2;
  localparam int QSIZE   = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic [2*NUM_REQ-1:0]   req_op = '0;
  logic [DW*NUM_REQ-1:0]  req_data = '0;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [DW-1:0]          rsp_data;
  logic                   rsp_err;
  logic                   q_wrt, q_read;
  logic [DW-1:0]          q_data;
  logic                   q_full = 1'b0, q_empty = 1'b1;
  logic [DW-1:0]          q_head = '0;

  always #5 clk = ~clk;

  pq_request_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .DATA_WIDTH    (DW),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .i_CLK       (clk),
    .i_RST       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op    (req_op),
    .i_req_data  (req_data),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_rsp_err   (rsp_err),
    .o_q_wrt     (q_wrt),
    .o_q_read    (q_read),
    .o_q_data    (q_data),
    .i_q_full    (q_full),
    .i_q_empty   (q_empty),
    .i_q_head    (q_head)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Behavioural priority queue (environment) driven by the DUT strobes
  logic [DW-1:0] pq[$];

  function automatic logic [DW-1:0] pq_max();
    logic [DW-1:0] m;
    m = '0;
    foreach (pq[i]) if (pq[i] > m) m = pq[i];
    return m;
  endfunction

  task automatic pq_remove_max();
    int bi;
    bi = -1;
    foreach (pq[i]) if (bi < 0 || pq[i] > pq[bi]) bi = i;
    if (bi >= 0) pq.delete(bi);
  endtask

  // Requesters
  bit            act [NUM_REQ];
  bit            keep[NUM_REQ];
  logic [1:0]    rop [NUM_REQ];
  logic [DW-1:0] rdat[NUM_REQ];
  bit            rand_mode = 0;
  bit            toggle1   = 0;
  bit            rst_req   = 1;

  // Arbitration reference model
  int            ptr_m   = 0;
  int            next_ok = 0;
  bit            pend    = 0;
  int            pend_g  = 0;
  logic [1:0]    pend_op = '0;
  logic [DW-1:0] pend_d  = '0;

  // Observation logs
  int            gnt_log[$];
  int            gnt_cyc[$];
  logic [DW-1:0] last_data[NUM_REQ];
  bit            last_err [NUM_REQ];
  int            rsp_cnt  [NUM_REQ];
  bit            saw_read = 0;
  bit            saw_both = 0;

  task automatic set_req(input int i, input logic [1:0] op, input logic [DW-1:0] d);
    act[i] = 1; rop[i] = op; rdat[i] = d;
  endtask

  task automatic cycle();
    logic [NUM_REQ-1:0] exp_ready, exp_rv;
    logic [DW-1:0]      exp_rd;
    bit                 exp_err, exp_w, exp_r, gv, err_m, ow, orr;
    int                 g, idx, sz;
    logic [DW-1:0]      od;
    @(negedge clk);
    cyc++;
    rst = rst_req;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rand_mode) begin
        if (!act[i] && $urandom_range(0, 99) < 30)
          set_req(i, 2'($urandom_range(0, 3)), DW'($urandom_range(0, 255)));
        else if (act[i] && $urandom_range(0, 99) < 5)
          act[i] = 0;
      end
    end
    if (toggle1 && !act[1] && $urandom_range(0, 1) == 1)
      set_req(1, 2'($urandom_range(1, 2)), DW'($urandom_range(0, 255)));
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]          = act[i];
      req_op[2*i +: 2]      = rop[i];
      req_data[DW*i +: DW]  = rdat[i];
    end
    sz      = pq.size();
    q_full  = (sz == QSIZE);
    q_empty = (sz == 0);
    q_head  = pq_max();
    #1;
    exp_ready = '0; gv = 0; g = 0;
    if (!rst && !pend && cyc >= next_ok) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (ptr_m + k) % NUM_REQ;
        if (act[idx] && !gv) begin gv = 1; g = idx; end
      end
    end
    if (gv) exp_ready[g] = 1'b1;
    exp_rv = '0; exp_err = 0; exp_rd = '0; exp_w = 0; exp_r = 0;
    if (pend && !rst) begin
      exp_rv[pend_g] = 1'b1;
      err_m   = (pend_op == 2'b00) || (pend_op == 2'b01 && sz == QSIZE) || (pend_op == 2'b10 && sz == 0);
      exp_err = err_m;
      if (!err_m) begin
        exp_w = pend_op[0];
        exp_r = pend_op[1];
        if (pend_op[1]) exp_rd = pq_max();
      end
    end
    check_eq("ready",     32'(req_ready), 32'(exp_ready));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check_eq("rsp_err",   32'(rsp_err),   32'(exp_err));
    check_eq("rsp_data",  32'(rsp_data),  32'(exp_rd));
    check_eq("q_wrt",     32'(q_wrt),     32'(exp_w));
    check_eq("q_read",    32'(q_read),    32'(exp_r));
    if (exp_w) check_eq("q_data", 32'(q_data), 32'(pend_d));
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin gnt_log.push_back(i); gnt_cyc.push_back(cyc); end
      if (rsp_valid[i]) begin last_data[i] = rsp_data; last_err[i] = rsp_err; rsp_cnt[i]++; end
    end
    ow = q_wrt; orr = q_read; od = q_data;
    if (orr) saw_read = 1;
    if (ow && orr) saw_both = 1;
    @(posedge clk);
    if (orr) pq_remove_max();
    if (ow && pq.size() < QSIZE) pq.push_back(od);
    if (rst) begin
      ptr_m = 0; pend = 0; next_ok = cyc + 1;
    end else begin
      pend = 0;
      if (gv) begin
        pend = 1; pend_g = g; pend_op = rop[g]; pend_d = rdat[g];
        ptr_m = (g + 1) % NUM_REQ;
        next_ok = cyc + 2 + SETTLE;
        if (keep[g]) begin
          rop[g]  = 2'($urandom_range(1, 2));
          rdat[g] = DW'($urandom_range(0, 255));
        end else begin
          act[g] = 0;
        end
      end
    end
  endtask

  function automatic bit any_act();
    bit a;
    a = 0;
    for (int i = 0; i < NUM_REQ; i++) a |= act[i];
    return a;
  endfunction

  task automatic run_quiet(input int budget);
    int n;
    n = 0;
    while ((any_act() || pend || cyc < next_ok) && n < budget) begin
      cycle();
      n++;
    end
    check_eq("quiet_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    gnt_cyc.delete();
    saw_read = 0;
    saw_both = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_cnt[i] = 0; last_err[i] = 0; last_data[i] = '0;
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin act[i] = 0; keep[i] = 0; end
    rst_req = 1;
    cycle();
    rst_req = 0;
    pq.delete();
    clear_logs();
  endtask

  function automatic int log_at(input int i);
    return (i < gnt_log.size()) ? gnt_log[i] : -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n;
    for (int i = 0; i < NUM_REQ; i++) begin
      act[i] = 0; keep[i] = 0; rop[i] = '0; rdat[i] = '0;
    end

    // Reset and idle state
    do_reset();
    cycle();

    // Single push on an empty queue
    set_req(0, 2'b01, 16'h0010);
    run_quiet(20);
    check_eq("t1_rsp_cnt",  32'(rsp_cnt[0]),   32'd1);
    check_eq("t1_rsp_err",  32'(last_err[0]),  32'd0);
    check_eq("t1_rsp_data", 32'(last_data[0]), 32'd0);
    clear_logs();
    keep[0] = 1;
    set_req(0, 2'b01, 16'h0011);
    for (int i = 0; i < 6; i++) cycle();
    keep[0] = 0;
    run_quiet(20);
    check_eq("t1_two_grants", 32'(gnt_cyc.size() >= 2), 32'd1);
    if (gnt_cyc.size() >= 2) check_eq("t1_accept_gap", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'(2 + SETTLE));

    // Four simultaneous pushes then two pops
    do_reset();
    set_req(0, 2'b01, 16'd5);
    set_req(1, 2'b01, 16'd9);
    set_req(2, 2'b01, 16'd3);
    set_req(3, 2'b01, 16'd7);
    run_quiet(40);
    check_eq("t2_grants", 32'(gnt_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_eq("t2_order", 32'(log_at(i)), 32'(i));
    set_req(1, 2'b10, 16'd0);
    run_quiet(20);
    check_eq("t2_pop1", 32'(last_data[1]), 32'h0009);
    set_req(2, 2'b10, 16'd0);
    run_quiet(20);
    check_eq("t2_pop2", 32'(last_data[2]), 32'h0007);

    // Pop on empty
    do_reset();
    set_req(2, 2'b10, 16'h1234);
    run_quiet(20);
    check_eq("t3_err",      32'(last_err[2]),  32'd1);
    check_eq("t3_data",     32'(last_data[2]), 32'd0);
    check_eq("t3_no_read",  32'(saw_read),     32'd0);
    check_eq("t3_q_size",   32'(pq.size()),    32'd0);

    // Full queue: push rejected, replace accepted
    do_reset();
    for (int v = 4; v >= 1; v--) begin
      set_req(0, 2'b01, DW'(v));
      run_quiet(20);
    end
    check_eq("t4_full", 32'(pq.size()), 32'd4);
    set_req(3, 2'b01, 16'd8);
    run_quiet(20);
    check_eq("t4_push_err", 32'(last_err[3]), 32'd1);
    set_req(3, 2'b11, 16'd8);
    run_quiet(20);
    check_eq("t4_repl_err",  32'(last_err[3]),  32'd0);
    check_eq("t4_repl_data", 32'(last_data[3]), 32'h0004);
    check_eq("t4_repl_both", 32'(saw_both),     32'd1);
    set_req(0, 2'b10, 16'd0);
    run_quiet(20);
    check_eq("t4_pop", 32'(last_data[0]), 32'h0008);

    // Fairness: req0 always valid, req1 toggles
    do_reset();
    keep[0] = 1;
    toggle1 = 1;
    set_req(0, 2'b01, 16'd1);
    n = 0;
    while (gnt_log.size() < 20 && n < 400) begin cycle(); n++; end
    check_eq("t5_in_budget", 32'(gnt_log.size() >= 20), 32'd1);
    n0 = 0;
    for (int i = 0; i < 20; i++) if (log_at(i) == 0) n0++;
    check_eq("t5_req0_share", 32'(n0 >= 10), 32'd1);
    keep[0] = 0;
    toggle1 = 0;
    run_quiet(40);

    // Reset during ISSUE aborts the op
    do_reset();
    set_req(1, 2'b01, 16'h0055);
    n = 0;
    while (!pend && n < 10) begin cycle(); n++; end
    check_eq("t6_reached_issue", 32'(pend), 32'd1);
    rst_req = 1;
    cycle();
    rst_req = 0;
    cycle();
    check_eq("t6_no_rsp",  32'(rsp_cnt[1]), 32'd0);
    check_eq("t6_q_size",  32'(pq.size()),  32'd0);
    gnt_log.delete();
    set_req(2, 2'b01, 16'h0022);
    set_req(3, 2'b01, 16'h0033);
    run_quiet(30);
    check_eq("t6_first_grant", 32'(log_at(0)), 32'd2);

    // Random traffic
    do_reset();
    rand_mode = 1;
    for (int i = 0; i < 500; i++) cycle();
    rand_mode = 0;
    run_quiet(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
